// File: rtl/alu_share_sched.sv
// Shares one combinational ALU between the core execute stage (requester 0) and the
// debug command port (requester 1), with round-robin arbitration and per-requester response slots.
package alu_share_sched_pkg;
    typedef enum logic [3:0] {
        OP_ADDU  = 4'd0,
        OP_SUBU  = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_BEQZ  = 4'd5,
        OP_BNEQZ = 4'd6
    } opcode_e;

    typedef struct packed {
        opcode_e    opcode;
        logic [4:0] dst;
    } instruction_s;
endpackage

module alu_share_sched
    import alu_share_sched_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              flush_i,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [31:0]       req0_rd_i,
    input  logic [31:0]       req0_rs_i,
    input  instruction_s      req0_op_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [31:0]       req1_rd_i,
    input  logic [31:0]       req1_rs_i,
    input  instruction_s      req1_op_i,
    output logic [31:0]       alu_rd_o,
    output logic [31:0]       alu_rs_o,
    output instruction_s      alu_op_o,
    input  logic [31:0]       alu_result_i,
    input  logic              alu_jump_now_i,
    output logic              resp0_valid_o,
    input  logic              resp0_ready_i,
    output logic [31:0]       resp0_result_o,
    output logic              resp0_jump_o,
    output logic              resp1_valid_o,
    input  logic              resp1_ready_i,
    output logic [31:0]       resp1_result_o,
    output logic              resp1_jump_o,
    output logic [CNT_W-1:0]  grant0_cnt_o,
    output logic [CNT_W-1:0]  grant1_cnt_o,
    output logic [CNT_W-1:0]  conflict_cnt_o
);

    // Handshake: a request transfers on a cycle with valid & ready; a response transfers
    // on a cycle with valid & ready. Ready depends only on valid, flush and slot state.
    logic elig0, elig1;
    logic grant0, grant1;
    logic rr_ptr;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // A full slot that is being drained this cycle counts as free.
    always_comb begin
        elig0  = req0_valid_i & ~flush_i & (~resp0_valid_o | resp0_ready_i);
        elig1  = req1_valid_i & ~flush_i & (~resp1_valid_o | resp1_ready_i);
        grant0 = elig0 & (~elig1 | ~rr_ptr);
        grant1 = elig1 & (~elig0 | rr_ptr);
    end

    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;

    always_comb begin
        alu_rd_o = req0_rd_i;
        alu_rs_o = req0_rs_i;
        alu_op_o = req0_op_i;
        if (grant1) begin
            alu_rd_o = req1_rd_i;
            alu_rs_o = req1_rs_i;
            alu_op_o = req1_op_i;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rr_ptr <= 1'b0;
        end else if (grant0) begin
            rr_ptr <= 1'b1;
        end else if (grant1) begin
            rr_ptr <= 1'b0;
        end
    end

    // Flush beats drain; grant beats drain so a slot can stream one result per cycle.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            resp0_valid_o  <= 1'b0;
            resp0_result_o <= '0;
            resp0_jump_o   <= 1'b0;
        end else if (flush_i) begin
            resp0_valid_o  <= 1'b0;
        end else if (grant0) begin
            resp0_valid_o  <= 1'b1;
            resp0_result_o <= alu_result_i;
            resp0_jump_o   <= alu_jump_now_i;
        end else if (resp0_ready_i) begin
            resp0_valid_o  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            resp1_valid_o  <= 1'b0;
            resp1_result_o <= '0;
            resp1_jump_o   <= 1'b0;
        end else if (flush_i) begin
            resp1_valid_o  <= 1'b0;
        end else if (grant1) begin
            resp1_valid_o  <= 1'b1;
            resp1_result_o <= alu_result_i;
            resp1_jump_o   <= alu_jump_now_i;
        end else if (resp1_ready_i) begin
            resp1_valid_o  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            grant0_cnt_o   <= '0;
            grant1_cnt_o   <= '0;
            conflict_cnt_o <= '0;
        end else begin
            if (grant0) grant0_cnt_o <= sat_inc(grant0_cnt_o);
            if (grant1) grant1_cnt_o <= sat_inc(grant1_cnt_o);
            if (elig0 && elig1) conflict_cnt_o <= sat_inc(conflict_cnt_o);
        end
    end

endmodule

// File: doc/alu_share_sched.md
Name: alu_share_sched

Overview:
- Time-shares one combinational `alu` instance between two requesters: requester 0 is the core execute stage, requester 1 is the auxiliary/debug command port.
- Handles valid/ready request arbitration with round-robin fairness.
- Muxes operands and opcode onto the ALU.
- Captures each result into a per-requester response register with its own valid/ready handshake.
- Sits between the requesters and the `alu` instance; it performs no opcode decode itself.

Parameters:
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  input  1  core clock; all state updates on rising edge
- n_reset  input  1  asynchronous active-low reset
- flush_i  input  1  synchronous flush of both response slots
- req0_valid_i  input  1  requester 0 has an operation
- req0_ready_o  output  1  requester 0 operation accepted this cycle
- req0_rd_i  input  32  requester 0 rd operand
- req0_rs_i  input  32  requester 0 rs operand
- req0_op_i  input  instruction_s  requester 0 instruction
- req1_valid_i, req1_ready_o, req1_rd_i, req1_rs_i, req1_op_i: same as requester 0, for requester 1
- alu_rd_o  output  32  operand to ALU rd_i
- alu_rs_o  output  32  operand to ALU rs_i
- alu_op_o  output  instruction_s  instruction to ALU op_i
- alu_result_i  input  32  ALU result_o
- alu_jump_now_i  input  1  ALU jump_now_o
- resp0_valid_o  output  1  response slot 0 holds a result
- resp0_ready_i  input  1  requester 0 consumes its response
- resp0_result_o  output  32  captured result
- resp0_jump_o  output  1  captured jump decision
- resp1_valid_o, resp1_ready_i, resp1_result_o, resp1_jump_o: same as response 0, for requester 1
- grant0_cnt_o  output  CNT_W  saturating count of requester 0 grants
- grant1_cnt_o  output  CNT_W  saturating count of requester 1 grants
- conflict_cnt_o  output  CNT_W  saturating count of cycles in which both requesters are eligible

Behaviour:
- Reset (n_reset low, asynchronous): resp*_valid_o=0, resp*_result_o=0, resp*_jump_o=0, rr_ptr=0, all counters=0. Takes effect immediately, including mid-transfer; in-flight results are discarded.
- Eligibility (combinational):
  - elig_k = reqk_valid_i & ~flush_i & (~respk_valid_o | respk_ready_i).
  - A full slot being drained in the same cycle counts as free, giving full throughput.
- Grant (combinational):
  - If only one requester is eligible, it is granted.
  - If both are eligible, requester rr_ptr is granted.
  - At most one grant per cycle. reqk_ready_o = grant_k. No ready→valid combinational path beyond this.
- ALU mux: alu_rd_o/alu_rs_o/alu_op_o carry the granted requester's fields. With no grant they carry requester 0's fields; the bench must not check ALU outputs in no-grant cycles.
- Capture:
  - On a rising edge with grant_k: slot k loads alu_result_i and alu_jump_now_i, and respk_valid_o=1 next cycle.
  - Latency is exactly 1 cycle from accept to response valid.
- Drain: respk_valid_o & respk_ready_i with no new grant_k clears valid. Data holds its last value.
- Simultaneous drain and grant on the same slot: valid stays 1 and new data loads (back-to-back, one result per cycle per requester).
- Response stability: while respk_valid_o=1 and respk_ready_i=0, result and jump are held stable.
- Jump field: resp*_jump_o is meaningful only for branch opcodes. For other opcodes the bench must ignore it, since the ALU drives X there.
- rr_ptr: after any grant to requester k, rr_ptr = ~k. Unchanged in cycles with no grant. A requester that keeps valid asserted waits at most 1 cycle behind the other.
- Flush:
  - Clears resp0_valid_o and resp1_valid_o at the next edge.
  - Forces both reqk_ready_o=0 in the flush cycle, so no capture occurs.
  - rr_ptr and counters are unchanged.
  - Flush overrides a simultaneous drain.
- Counters:
  - grantk_cnt increments on each grant_k.
  - conflict_cnt increments when elig_0 & elig_1.
  - All counters saturate at 2^CNT_W-1; no wrap-around.
- Requesters must hold valid and operands stable until ready. Deasserting valid without ready is tolerated, and the operation is simply never issued.

Test Plan:
- Reset check: assert n_reset=0 mid-cycle with resp0 valid → resp0_valid_o drops immediately; all counters=0, rr_ptr=0.
- Single requester back-to-back: req0 ADDU 5+7 then SUBU 9-3, resp0_ready_i=1 throughout → ready every cycle; resp0_result_o=12 then 6 on consecutive cycles; grant0_cnt_o=2.
- Contention: both valid continuously with AND and OR operands, both resp ready → grants alternate 0,1,0,1; conflict_cnt_o increments every cycle; each response is correct 1 cycle after its own grant.
- Backpressure: resp1_ready_i=0 with slot 1 full and req1 valid → req1_ready_o=0, resp1_result_o stable; raise ready → same-cycle regrant, new result next cycle.
- Flush during contention: flush_i=1 with both slots full and both valid → no ready in that cycle; both resp valid=0 next cycle; rr_ptr unchanged.
- Saturation: CNT_W=4, 20 grants to requester 0 → grant0_cnt_o holds at 15; BEQZ rd=0 → resp0_jump_o=1; BNEQZ rd=0 → resp0_jump_o=0.
